// File: rtl/rush3d_framebuffer_writer.sv
// ---------------------------------------------------------------------------------------------
// rush3d_framebuffer_writer
//
// This block is the consumer side of the rush3d control path. It queues raster pixels in a
// small FIFO and turns each one into a framebuffer memory write. When the controller asks for a
// background fill, the block drops the queued pixels and writes the latched background colour
// to every word of the framebuffer, in address order.
//
// framebuffer_write_state reports the FSM state: 0=WAIT 1=WRITE 2=PURGE 3=BACKGROUND. The
// controller watches this output to retire a fill request.
//
// Optional feature: define FB_BOUNDS_CHECK_EN to enable bounds checking. A pixel that lies
// outside the framebuffer is then dropped, and the sticky pixel_clip_flag is set. When the
// macro is undefined, out-of-range coordinates wrap through the truncated address arithmetic
// and pixel_clip_flag stays 0.
//
// Ports
//   clock                   in   system clock
//   reset_n                 in   asynchronous reset, active low
//   fill_background_flag    in   fill request from controller (level)
//   background_colour       in   fill colour, captured in PURGE
//   pixel_valid/ready       in/out pixel handshake (push on valid && ready)
//   pixel_x/pixel_y         in   pixel coordinates
//   pixel_colour            in   pixel colour
//   fb_address              out  write word address (registered)
//   fb_writedata            out  write data (registered)
//   fb_write                out  write strobe (registered)
//   fb_waitrequest          in   slave stall; write accepted when fb_write && !fb_waitrequest
//   framebuffer_write_state out  FSM state (registered)
//   pixel_clip_flag         out  sticky out-of-bounds indicator (bounds-check build only)
// ---------------------------------------------------------------------------------------------
module rush3d_framebuffer_writer #(
  parameter int unsigned FB_WIDTH   = 640,
  parameter int unsigned FB_HEIGHT  = 480,
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 10,
  parameter int unsigned COLOUR_W   = 16,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FB_BASE    = 0,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                fill_background_flag,
  input  logic [COLOUR_W-1:0] background_colour,
  input  logic                pixel_valid,
  output logic                pixel_ready,
  input  logic [X_W-1:0]      pixel_x,
  input  logic [Y_W-1:0]      pixel_y,
  input  logic [COLOUR_W-1:0] pixel_colour,
  output logic [ADDR_W-1:0]   fb_address,
  output logic [COLOUR_W-1:0] fb_writedata,
  output logic                fb_write,
  input  logic                fb_waitrequest,
  output logic [3:0]          framebuffer_write_state,
  output logic                pixel_clip_flag
);

  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned ENTRY_W    = X_W + Y_W + COLOUR_W;
  localparam int unsigned FILL_TOTAL = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned CNT_W      = $clog2(FILL_TOTAL + 1);

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(FB_BASE);
  localparam logic [CNT_W-1:0]  FILL_LAST = CNT_W'(FILL_TOTAL - 1);
  localparam logic [CNT_W-1:0]  FILL_DONE = CNT_W'(FILL_TOTAL);

  typedef enum logic [1:0] {
    StWait       = 2'd0,
    StWrite      = 2'd1,
    StPurge      = 2'd2,
    StBackground = 2'd3
  } state_e;

  // ------------------------------------------------------------------------------------------
  // Pixel FIFO. The pointers carry one extra wrap bit so the FIFO can tell full from empty.
  // ------------------------------------------------------------------------------------------
  logic [ENTRY_W-1:0] r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]     r_wr_ptr;
  logic [PTR_W:0]     r_rd_ptr;
  logic [PTR_W:0]     w_wr_ptr_d;
  logic [PTR_W:0]     w_rd_ptr_d;
  logic               w_fifo_empty;
  logic               w_full_d;
  logic               w_push;
  logic               w_pop;
  logic               w_fifo_clear;

  logic [ENTRY_W-1:0]  w_head;
  logic [X_W-1:0]      w_head_x;
  logic [Y_W-1:0]      w_head_y;
  logic [COLOUR_W-1:0] w_head_colour;
  logic [ADDR_W-1:0]   w_head_addr;
  logic                w_head_clip;

  // FSM and output registers
  state_e              r_state;
  state_e              w_state_d;
  logic [ADDR_W-1:0]   r_fb_address;
  logic [ADDR_W-1:0]   w_fb_address_d;
  logic [COLOUR_W-1:0] r_fb_writedata;
  logic [COLOUR_W-1:0] w_fb_writedata_d;
  logic                r_fb_write;
  logic                w_fb_write_d;
  logic [CNT_W-1:0]    r_fill_cnt;
  logic [CNT_W-1:0]    w_fill_cnt_d;
  logic                r_pixel_ready;
  logic                w_pixel_ready_d;
  logic                w_accept;
  logic                w_fill_done;

  assign w_push       = pixel_valid && r_pixel_ready;
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr[PTR_W-1:0]] <= {pixel_x, pixel_y, pixel_colour};
    end
  end

  assign w_head        = r_fifo_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_head_x      = w_head[ENTRY_W-1 -: X_W];
  assign w_head_y      = w_head[COLOUR_W +: Y_W];
  assign w_head_colour = w_head[COLOUR_W-1:0];

  // The address wraps modulo 2^ADDR_W when the coordinates are out of range.
  assign w_head_addr = BASE_ADDR + ADDR_W'(w_head_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(w_head_x);

`ifdef FB_BOUNDS_CHECK_EN
  assign w_head_clip = (32'(w_head_x) >= FB_WIDTH) || (32'(w_head_y) >= FB_HEIGHT);
`else
  assign w_head_clip = 1'b0;
`endif

  always_comb begin
    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;
    if (w_fifo_clear) begin
      // No push can coincide with the clear: ready is low throughout PURGE.
      w_wr_ptr_d = '0;
      w_rd_ptr_d = '0;
    end else begin
      if (w_push) w_wr_ptr_d = r_wr_ptr + (PTR_W + 1)'(1);
      if (w_pop)  w_rd_ptr_d = r_rd_ptr + (PTR_W + 1)'(1);
    end
  end

  assign w_full_d = (w_wr_ptr_d[PTR_W] != w_rd_ptr_d[PTR_W]) &&
                    (w_wr_ptr_d[PTR_W-1:0] == w_rd_ptr_d[PTR_W-1:0]);

  // ready is registered and computed from next-cycle occupancy and state. It therefore equals
  // !full && state in {WAIT, WRITE} for the current cycle, and it reads 0 while in reset.
  assign w_pixel_ready_d = !w_full_d && ((w_state_d == StWait) || (w_state_d == StWrite));

  // ------------------------------------------------------------------------------------------
  // Next-state and output logic
  // ------------------------------------------------------------------------------------------
  assign w_accept    = r_fb_write && !fb_waitrequest;
  assign w_fill_done = (r_fill_cnt == FILL_DONE);

  always_comb begin
    w_state_d        = r_state;
    w_fb_address_d   = r_fb_address;
    w_fb_writedata_d = r_fb_writedata;
    w_fb_write_d     = r_fb_write;
    w_fill_cnt_d     = r_fill_cnt;
    w_pop            = 1'b0;
    w_fifo_clear     = 1'b0;

    unique case (r_state)
      StWait: begin
        if (fill_background_flag) begin
          w_state_d = StPurge;
        end else if (!w_fifo_empty) begin
          w_pop = 1'b1;
          if (w_head_clip) begin
            // The clipped pixel uses up this pop slot and produces no write.
            w_fb_write_d = 1'b0;
            w_state_d    = StWait;
          end else begin
            w_fb_address_d   = w_head_addr;
            w_fb_writedata_d = w_head_colour;
            w_fb_write_d     = 1'b1;
            w_state_d        = StWrite;
          end
        end
      end

      StWrite: begin
        // A pending write is only retired by acceptance, so a fill request never aborts it.
        if (w_accept) begin
          if (fill_background_flag) begin
            w_fb_write_d = 1'b0;
            w_state_d    = StPurge;
          end else if (!w_fifo_empty) begin
            w_pop = 1'b1;
            if (w_head_clip) begin
              w_fb_write_d = 1'b0;
              w_state_d    = StWait;
            end else begin
              w_fb_address_d   = w_head_addr;
              w_fb_writedata_d = w_head_colour;
              w_fb_write_d     = 1'b1;
            end
          end else begin
            w_fb_write_d = 1'b0;
            w_state_d    = StWait;
          end
        end
      end

      StPurge: begin
        // Drop queued pixels and preload the first fill write. fb_writedata keeps the captured
        // colour for the whole fill.
        w_fifo_clear     = 1'b1;
        w_fill_cnt_d     = '0;
        w_fb_address_d   = BASE_ADDR;
        w_fb_writedata_d = background_colour;
        w_fb_write_d     = 1'b1;
        w_state_d        = StBackground;
      end

      StBackground: begin
        if (w_accept) begin
          w_fill_cnt_d = r_fill_cnt + CNT_W'(1);
          if (r_fill_cnt == FILL_LAST) begin
            w_fb_write_d = 1'b0;
          end else begin
            w_fb_address_d = BASE_ADDR + ADDR_W'(w_fill_cnt_d);
          end
        end
        // A request that is still high at completion is held here, so no refill starts.
        if (w_fill_done && !fill_background_flag) begin
          w_state_d = StWait;
        end
      end

      default: begin
        w_state_d    = StWait;
        w_fb_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= StWait;
      r_fb_address   <= '0;
      r_fb_writedata <= '0;
      r_fb_write     <= 1'b0;
      r_fill_cnt     <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_pixel_ready  <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_fb_address   <= w_fb_address_d;
      r_fb_writedata <= w_fb_writedata_d;
      r_fb_write     <= w_fb_write_d;
      r_fill_cnt     <= w_fill_cnt_d;
      r_wr_ptr       <= w_wr_ptr_d;
      r_rd_ptr       <= w_rd_ptr_d;
      r_pixel_ready  <= w_pixel_ready_d;
    end
  end

`ifdef FB_BOUNDS_CHECK_EN
  logic r_clip;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clip <= 1'b0;
    end else if (w_pop && w_head_clip) begin
      r_clip <= 1'b1;
    end
  end

  assign pixel_clip_flag = r_clip;
`else
  assign pixel_clip_flag = 1'b0;
`endif

  assign pixel_ready             = r_pixel_ready;
  assign fb_address              = r_fb_address;
  assign fb_writedata            = r_fb_writedata;
  assign fb_write                = r_fb_write;
  assign framebuffer_write_state = {2'b00, r_state};

endmodule

// File: tb/tb_rush3d_framebuffer_writer.sv
// Bench for rush3d_framebuffer_writer using a small framebuffer configuration (4x2, base
// 0x100, FIFO depth 4). A queue of expected writes, built from the pixel handshakes and the
// fill rules, is checked against every accepted framebuffer write.
module tb_rush3d_framebuffer_writer;

  localparam int unsigned W     = 4;
  localparam int unsigned H     = 2;
  localparam int unsigned BASE  = 32'h100;
  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fill_background_flag = 1'b0;
  logic [15:0] background_colour = '0;
  logic        pixel_valid = 1'b0;
  logic        pixel_ready;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic [15:0] pixel_colour = '0;
  logic [31:0] fb_address;
  logic [15:0] fb_writedata;
  logic        fb_write;
  logic        fb_waitrequest = 1'b0;
  logic [3:0]  framebuffer_write_state;
  logic        pixel_clip_flag;

  rush3d_framebuffer_writer #(
    .FB_WIDTH   (W),
    .FB_HEIGHT  (H),
    .X_W        (10),
    .Y_W        (10),
    .COLOUR_W   (16),
    .ADDR_W     (32),
    .FB_BASE    (BASE),
    .FIFO_DEPTH (DEPTH)
  ) u_dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .fill_background_flag    (fill_background_flag),
    .background_colour       (background_colour),
    .pixel_valid             (pixel_valid),
    .pixel_ready             (pixel_ready),
    .pixel_x                 (pixel_x),
    .pixel_y                 (pixel_y),
    .pixel_colour            (pixel_colour),
    .fb_address              (fb_address),
    .fb_writedata            (fb_writedata),
    .fb_write                (fb_write),
    .fb_waitrequest          (fb_waitrequest),
    .framebuffer_write_state (framebuffer_write_state),
    .pixel_clip_flag         (pixel_clip_flag)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the ordered list of writes the framebuffer must receive.
  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_writes = 0;

  // Slave stall generator: either a forced level or random stalls.
  bit wr_rand  = 1'b0;
  bit wr_force = 1'b0;

  always @(posedge clock) begin
    #2;
    fb_waitrequest = wr_rand ? ($urandom_range(0, 2) == 0) : wr_force;
  end

  // Monitor: all DUT outputs are sampled on the falling edge.
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [15:0] prev_data = '0;
  int          purge_run = 0;

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
      purge_run  = 0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_write", 32'(fb_write), 32'd1);
        check_eq("stall_addr", fb_address, prev_addr);
        check_eq("stall_data", 32'(fb_writedata), 32'(prev_data));
      end
      prev_stall = fb_write && fb_waitrequest;
      prev_addr  = fb_address;
      prev_data  = fb_writedata;

      if (fb_write && !fb_waitrequest) begin
        wr_t e;
        n_writes++;
        check_eq("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("write_addr", fb_address, e.addr);
          check_eq("write_data", 32'(fb_writedata), 32'(e.data));
        end
      end

      if (framebuffer_write_state == 4'd2) begin
        purge_run++;
      end else if (purge_run != 0) begin
        check_eq("purge_len", 32'(purge_run), 32'd1);
        purge_run = 0;
      end

      if (framebuffer_write_state >= 4'd2) begin
        check_eq("ready_in_fill", 32'(pixel_ready), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    return BASE + 32'(y) * W + 32'(x);
  endfunction

  // Offer one pixel and wait (bounded) for the handshake; the model records the write.
  task automatic push_pixel(input logic [9:0] x, input logic [9:0] y, input logic [15:0] c,
                            input bit expect_wr);
    int  t;
    wr_t e;
    pixel_x      = x;
    pixel_y      = y;
    pixel_colour = c;
    pixel_valid  = 1'b1;
    t = 0;
    @(negedge clock);
    while (!pixel_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    check_eq("push_accepted", 32'(pixel_ready), 32'd1);
    @(posedge clock);
    #1;
    pixel_valid = 1'b0;
    if (expect_wr && t < 100) begin
      e.addr = pix_addr(x, y);
      e.data = c;
      exp_q.push_back(e);
    end
  endtask

  task automatic add_fill(input logic [15:0] colour);
    wr_t e;
    for (int i = 0; i < int'(W * H); i++) begin
      e.addr = BASE + 32'(i);
      e.data = colour;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clock);
      t++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_writes(input int target);
    int t = 0;
    while (n_writes < target && t < 500) begin
      @(negedge clock);
      t++;
    end
    check_eq("write_count_reached", 32'(n_writes >= target), 32'd1);
  endtask

  task automatic wait_state(input logic [3:0] st, input int budget);
    int t = 0;
    @(negedge clock);
    while (framebuffer_write_state != st && t < budget) begin
      @(negedge clock);
      t++;
    end
    check_eq("state_reached", 32'(framebuffer_write_state), 32'(st));
  endtask

  initial begin
    int          base;
    int          lat;
    logic [15:0] bg;
    wr_t         head;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_write", 32'(fb_write), 32'd0);
    check_eq("rst_addr", fb_address, 32'd0);
    check_eq("rst_data", 32'(fb_writedata), 32'd0);
    check_eq("rst_state", 32'(framebuffer_write_state), 32'd0);
    check_eq("rst_ready", 32'(pixel_ready), 32'd0);
    check_eq("rst_clip", 32'(pixel_clip_flag), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    step();
    @(negedge clock);
    check_eq("idle_ready", 32'(pixel_ready), 32'd1);

    // Single pixel: write two cycles after the handshake, WRITE then WAIT
    step();
    base = n_writes;
    push_pixel(10'd2, 10'd1, 16'hF800, 1'b1);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!fb_write && lat < 10);
    check_eq("latency", 32'(lat), 32'd2);
    check_eq("single_state_write", 32'(framebuffer_write_state), 32'd1);
    check_eq("single_addr", fb_address, 32'h106);
    @(negedge clock);
    check_eq("single_state_wait", 32'(framebuffer_write_state), 32'd0);
    check_eq("single_write_low", 32'(fb_write), 32'd0);
    check_eq("single_count", 32'(n_writes - base), 32'd1);

    // Fill the FIFO behind a stalled write
    step();
    wr_force = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_pixel(10'($urandom_range(0, W - 1)), 10'($urandom_range(0, H - 1)),
                 16'($urandom), 1'b1);
    end
    @(negedge clock);
    check_eq("full_ready", 32'(pixel_ready), 32'd0);
    check_eq("full_write_held", 32'(fb_write), 32'd1);
    check_eq("full_head_addr", fb_address, exp_q[0].addr);
    repeat (3) @(negedge clock);
    step();
    wr_force = 1'b0;
    wait_drain();
    @(negedge clock);
    check_eq("drained_ready", 32'(pixel_ready), 32'd1);

    // Fill request while a write is stalled and three pixels are queued.
    // Drop the request after two fill writes.
    step();
    wr_force = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_pixel(10'($urandom_range(0, W - 1)), 10'($urandom_range(0, H - 1)),
                 16'($urandom), 1'b1);
    end
    head = exp_q[0];
    exp_q.delete();
    exp_q.push_back(head);
    bg = 16'h001F;
    add_fill(bg);
    base = n_writes;
    background_colour    = bg;
    fill_background_flag = 1'b1;
    step();
    step();
    wr_rand = 1'b1;
    wait_writes(base + 3);
    step();
    fill_background_flag = 1'b0;
    wait_drain();
    wait_state(4'd0, 20);
    check_eq("fill1_count", 32'(n_writes - base), 32'(1 + W * H));

    // Fill request held high past completion: hold in BACKGROUND, no refill
    step();
    bg = 16'($urandom);
    background_colour = bg;
    add_fill(bg);
    base = n_writes;
    fill_background_flag = 1'b1;
    wait_drain();
    wr_rand  = 1'b0;
    wr_force = 1'b0;
    repeat (10) @(negedge clock);
    check_eq("hold_state", 32'(framebuffer_write_state), 32'd3);
    check_eq("hold_no_write", 32'(fb_write), 32'd0);
    check_eq("hold_count", 32'(n_writes - base), 32'(W * H));
    step();
    fill_background_flag = 1'b0;
    wait_state(4'd0, 5);

    // Reset in the middle of a fill
    step();
    bg = 16'($urandom);
    background_colour = bg;
    add_fill(bg);
    base = n_writes;
    fill_background_flag = 1'b1;
    wait_writes(base + 3);
    step();
    reset_n = 1'b0;
    fill_background_flag = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check_eq("midrst_write", 32'(fb_write), 32'd0);
    check_eq("midrst_addr", fb_address, 32'd0);
    check_eq("midrst_data", 32'(fb_writedata), 32'd0);
    check_eq("midrst_state", 32'(framebuffer_write_state), 32'd0);
    check_eq("midrst_ready", 32'(pixel_ready), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    base = n_writes;
    repeat (10) @(negedge clock);
    check_eq("post_rst_state", 32'(framebuffer_write_state), 32'd0);
    check_eq("post_rst_write", 32'(fb_write), 32'd0);
    check_eq("post_rst_count", 32'(n_writes - base), 32'd0);
    check_eq("post_rst_ready", 32'(pixel_ready), 32'd1);

    // Random pixel traffic with random stalls
    step();
    wr_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) step();
      push_pixel(10'($urandom_range(0, W - 1)), 10'($urandom_range(0, H - 1)),
                 16'($urandom), 1'b1);
    end
    wait_drain();
    wr_rand = 1'b0;
    wait_state(4'd0, 10);
`ifndef FB_BOUNDS_CHECK_EN
    check_eq("clip_tied_low", 32'(pixel_clip_flag), 32'd0);
`endif

`ifdef FB_BOUNDS_CHECK_EN
    // An out-of-bounds pixel is dropped and sets the sticky clip flag
    step();
    base = n_writes;
    push_pixel(10'd4, 10'd0, 16'h1234, 1'b0);
    push_pixel(10'd0, 10'd0, 16'h5678, 1'b1);
    wait_drain();
    repeat (3) @(negedge clock);
    check_eq("clip_count", 32'(n_writes - base), 32'd1);
    check_eq("clip_flag", 32'(pixel_clip_flag), 32'd1);
    step();
    push_pixel(10'd1, 10'd1, 16'h9ABC, 1'b1);
    wait_drain();
    check_eq("clip_sticky", 32'(pixel_clip_flag), 32'd1);
`endif

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
